// File: rtl/truth_table_sweep_if.sv
// Bundles the sweep controller's stimulus/capture signals. The slave side is
// the sweep controller; the master side is whatever owns start and the gate.
interface truth_table_sweep_if #(
    parameter int N_IN = 3
);
    logic                   start;
    logic                   f_in;
    logic [N_IN-1:0]        vec_out;
    logic                   busy;
    logic                   done;
    logic [(2**N_IN)-1:0]   table_out;
    logic                   pass;
    logic [N_IN-1:0]        fail_idx;

    modport master (
        output start, f_in,
        input  vec_out, busy, done, table_out, pass, fail_idx
    );

    modport slave (
        input  start, f_in,
        output vec_out, busy, done, table_out, pass, fail_idx
    );
endinterface

// File: rtl/truth_table_sweep.sv
// Clocked truth-table sweep: walks vec_out through every input combination,
// holds each vector SETTLE+1 cycles, captures the gate output into table_out
// and grades the finished table against EXPECTED.
//
// state  | meaning
// IDLE   | waiting for start; last results held
// DRIVE  | vector applied, counting settle cycles
// SAMPLE | capture f_in for current vector, advance or finish
// DONE   | one-cycle done pulse, results valid
module truth_table_sweep #(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0] EXPECTED = 8'hD5
) (
    input  logic               clk,
    input  logic               rst,
    truth_table_sweep_if.slave bus
);
    localparam int DEPTH = 2**N_IN;
    localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     settle_cnt;
    logic [N_IN-1:0]   vec_q;
    logic [DEPTH-1:0]  table_q;
    logic [DEPTH-1:0]  table_nx;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [N_IN-1:0]   fail_q;
    logic              settle_hit;
    logic              vec_last;

    // Lowest set bit of the mismatch vector; zero when there is no mismatch.
    function automatic logic [N_IN-1:0] lowest_set(input logic [DEPTH-1:0] v);
        lowest_set = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = N_IN'(i);
        end
    endfunction

    assign settle_hit = (settle_cnt == CW'(SETTLE - 1));
    assign vec_last   = &vec_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = DRIVE;
            DRIVE:   if (settle_hit) state_nx = SAMPLE;
            SAMPLE:  state_nx = vec_last ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Table with the current vector's result merged in, used by capture and grading.
    always_comb begin
        table_nx        = table_q;
        table_nx[vec_q] = bus.f_in;
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            vec_q      <= '0;
            table_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= '0;
        end else begin
            busy_q <= (state_nx == DRIVE) || (state_nx == SAMPLE);
            done_q <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        settle_cnt <= '0;
                        vec_q      <= '0;
                        table_q    <= '0;
                        pass_q     <= 1'b0;
                        fail_q     <= '0;
                    end
                end
                DRIVE: begin
                    if (!settle_hit) settle_cnt <= settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    table_q    <= table_nx;
                    settle_cnt <= '0;
                    if (!vec_last) begin
                        vec_q <= vec_q + 1'b1;
                    end else begin
                        // Counter parks at zero rather than wrapping into a new pass.
                        vec_q  <= '0;
                        pass_q <= (table_nx == EXPECTED);
                        fail_q <= lowest_set(table_nx ^ EXPECTED);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vec_out   = vec_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.table_out = table_q;
    assign bus.pass      = pass_q;
    assign bus.fail_idx  = fail_q;
endmodule

// File: tb/tb_truth_table_sweep.sv
module tb_truth_table_sweep;
    logic clk = 1'b0;
    logic rst;
    int   mode;    // 0: ~c | a&b, 1: stuck-0, 2: ~c
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        logic [7:0] tbl;
        logic       pas;
        logic [2:0] idx;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];

    truth_table_sweep_if #(.N_IN(3)) bif ();

    truth_table_sweep dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test, selectable between the good gate and two faults.
    logic ga, gb, gc;
    assign ga = bif.vec_out[2];
    assign gb = bif.vec_out[1];
    assign gc = bif.vec_out[0];
    assign bif.f_in = (mode == 0) ? (~gc | (ga & gb)) :
                      (mode == 1) ? 1'b0 : ~gc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    logic after_done = 1'b0;
    always @(negedge clk) begin
        if (after_done) begin
            chk("done_one_cycle", {31'd0, bif.done}, 32'd0);
            chk("idle_after_done_busy", {31'd0, bif.busy}, 32'd0);
        end
        after_done <= bif.done;
        if (bif.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.done_cyc);
                chk("table_out", {24'd0, bif.table_out}, {24'd0, e.tbl});
                chk("pass", {31'd0, bif.pass}, {31'd0, e.pas});
                chk("fail_idx", {29'd0, bif.fail_idx}, {29'd0, e.idx});
                chk("vec_out_in_done", {29'd0, bif.vec_out}, 32'd0);
                chk("busy_in_done", {31'd0, bif.busy}, 32'd0);
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 120 && sb.size() > 0; i++) @(negedge clk);
        chk(name, sb.size(), 32'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Pulse start for one cycle from IDLE; returns the accepting edge number.
    task automatic pulse_start(output int acc);
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        acc = cyc;
    endtask

    task automatic push_exp(input logic [7:0] t, input logic p, input logic [2:0] ix, input int dc);
        exp_t e;
        e.tbl = t; e.pas = p; e.idx = ix; e.done_cyc = dc;
        sb.push_back(e);
    endtask

    initial begin
        int acc;
        mode      = 0;
        bif.start = 1'b1;
        rst       = 1'b1;

        // T1: reset (with start asserted) leaves everything cleared.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_vec_out", {29'd0, bif.vec_out}, 32'd0);
        chk("rst_busy", {31'd0, bif.busy}, 32'd0);
        chk("rst_done", {31'd0, bif.done}, 32'd0);
        chk("rst_table", {24'd0, bif.table_out}, 32'd0);
        chk("rst_pass", {31'd0, bif.pass}, 32'd0);
        chk("rst_fail_idx", {29'd0, bif.fail_idx}, 32'd0);
        bif.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        chk("idle_no_start_busy", {31'd0, bif.busy}, 32'd0);

        // T2: nominal sweep, also checking each vector is held 3 cycles.
        mode = 0;
        pulse_start(acc);
        push_exp(8'hD5, 1'b1, 3'd0, acc + 24);
        for (int k = 0; k < 24; k++) begin
            chk("vec_hold", {29'd0, bif.vec_out}, k / 3);
            chk("busy_sweep", {31'd0, bif.busy}, 32'd1);
            @(negedge clk);
        end
        wait_drain("t2_drain");
        chk("hold_table_idle", {24'd0, bif.table_out}, 32'hD5);
        chk("hold_pass_idle", {31'd0, bif.pass}, 32'd1);

        // T3: stuck-0 gate.
        mode = 1;
        pulse_start(acc);
        push_exp(8'h00, 1'b0, 3'd0, acc + 24);
        wait_drain("t3_drain");

        // T4: gate missing the a&b term.
        mode = 2;
        pulse_start(acc);
        push_exp(8'h55, 1'b0, 3'd7, acc + 24);
        wait_drain("t4_drain");

        // T5: reset in the middle of a sweep aborts it cleanly.
        mode = 0;
        pulse_start(acc);
        for (int i = 0; i < 40 && bif.vec_out != 3'd4; i++) @(negedge clk);
        chk("t5_reached_vec4", {29'd0, bif.vec_out}, 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_vec_out", {29'd0, bif.vec_out}, 32'd0);
        chk("t5_table", {24'd0, bif.table_out}, 32'd0);
        chk("t5_busy", {31'd0, bif.busy}, 32'd0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bif.busy) chk("t5_no_resume", 32'd1, 32'd0);
        end
        pulse_start(acc);
        push_exp(8'hD5, 1'b1, 3'd0, acc + 24);
        wait_drain("t5_drain");

        // T6: start held high. Restart needs DONE->IDLE then an IDLE edge,
        // so accepts are 26 edges apart and nothing restarts mid-sweep.
        mode = 0;
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        acc = cyc;
        push_exp(8'hD5, 1'b1, 3'd0, acc + 24);
        push_exp(8'hD5, 1'b1, 3'd0, acc + 50);
        for (int i = 0; i < 80 && sb.size() > 0; i++) @(negedge clk);
        bif.start = 1'b0;
        chk("t6_drain", sb.size(), 32'd0);
        for (int i = 0; i < 30; i++) @(negedge clk);
        chk("t6_stopped_busy", {31'd0, bif.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end
endmodule
